// File: rtl/pack_if.sv
// Handshake bundle for pack: serial argument channel in, packed word channel out.
// Signals: arg_stb/arg_dat/arg_rdy (argument side), out_stb/out_dat/out_rdy (word side).
// master = environment driving arguments and consuming words; slave = the packer itself.
interface pack_if #(
    parameter int ARGW = 8,
    parameter int ARGD = 2
);
    logic                 arg_stb;
    logic [ARGW-1:0]      arg_dat;
    logic                 arg_rdy;
    logic                 out_stb;
    logic [ARGD*ARGW-1:0] out_dat;
    logic                 out_rdy;

    modport master (
        output arg_stb, arg_dat, out_rdy,
        input  arg_rdy, out_stb, out_dat
    );

    modport slave (
        input  arg_stb, arg_dat, out_rdy,
        output arg_rdy, out_stb, out_dat
    );
endinterface

// File: rtl/pack.sv
// Purpose: packs ARGD serial ARGW-bit arguments into one word, lane 0 in the LSBs.
// Latency: word valid one cycle after its final argument is accepted.
// Backpressure: only the final lane stalls while a completed word waits on out_rdy.
// Ports: clk, rst (async active-low), bus (pack_if.slave: arg_* in, out_* out).
module pack #(
    parameter int ARGW = 8,
    parameter int ARGD = 2
) (
    input  logic  clk,
    input  logic  rst,
    pack_if.slave bus
);
    localparam int              IDXW = $clog2(ARGD);
    localparam logic [IDXW-1:0] LAST = IDXW'(ARGD - 1);

    logic [IDXW-1:0]          idx_q, idx_d;
    logic [(ARGD-1)*ARGW-1:0] acc_q, acc_d;
    logic [ARGD*ARGW-1:0]     out_dat_q, out_dat_d;
    logic                     out_stb_q, out_stb_d;

    logic arg_rdy;
    logic arg_ack;
    logic out_ack;

    // Lanes before the final one always have somewhere to go (the accumulator),
    // so only the final lane needs the output register to be free or draining.
    assign arg_rdy = (idx_q != LAST) | ~out_stb_q | bus.out_rdy;
    assign arg_ack = bus.arg_stb & arg_rdy;
    assign out_ack = out_stb_q & bus.out_rdy;

    always_comb begin
        idx_d     = idx_q;
        acc_d     = acc_q;
        out_dat_d = out_dat_q;
        out_stb_d = out_stb_q;

        if (out_ack) begin
            out_stb_d = 1'b0;
        end

        if (arg_ack) begin
            if (idx_q == LAST) begin
                // Overrides the clear above when a word drains and refills on one edge.
                out_dat_d = {bus.arg_dat, acc_q};
                out_stb_d = 1'b1;
                idx_d     = '0;
            end else begin
                for (int k = 0; k < ARGD - 1; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        acc_d[k*ARGW +: ARGW] = bus.arg_dat;
                    end
                end
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            acc_q     <= '0;
            out_dat_q <= '0;
            out_stb_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            out_dat_q <= out_dat_d;
            out_stb_q <= out_stb_d;
        end
    end

    assign bus.arg_rdy = arg_rdy;
    assign bus.out_stb = out_stb_q;
    assign bus.out_dat = out_dat_q;
endmodule

// File: tb/tb_pack.sv
module tb_pack;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pack_if #(.ARGW(8), .ARGD(2)) if2 ();
    pack_if #(.ARGW(8), .ARGD(3)) if3 ();

    pack #(.ARGW(8), .ARGD(2)) u_pack2 (.clk(clk), .rst(rst), .bus(if2.slave));
    pack #(.ARGW(8), .ARGD(3)) u_pack3 (.clk(clk), .rst(rst), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if2.arg_stb = 1'b0; if2.arg_dat = '0; if2.out_rdy = 1'b0;
        if3.arg_stb = 1'b0; if3.arg_dat = '0; if3.out_rdy = 1'b0;
        #12;
        total++; if (if2.out_stb !== 1'b0) begin bad++; $display("FAIL reset_stb2 got=%b exp=0", if2.out_stb); end
        total++; if (if2.out_dat !== 16'h0) begin bad++; $display("FAIL reset_dat2 got=%h exp=0000", if2.out_dat); end
        total++; if (if2.arg_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy2 got=%b exp=1", if2.arg_rdy); end
        total++; if (if3.out_stb !== 1'b0) begin bad++; $display("FAIL reset_stb3 got=%b exp=0", if3.out_stb); end
        total++; if (if3.out_dat !== 24'h0) begin bad++; $display("FAIL reset_dat3 got=%h exp=000000", if3.out_dat); end
        total++; if (if3.arg_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy3 got=%b exp=1", if3.arg_rdy); end
        tick();
        rst = 1'b1;
        tick();
        total++; if (if2.arg_rdy !== 1'b1) begin bad++; $display("FAIL post_reset_rdy got=%b exp=1", if2.arg_rdy); end
    endtask

    task automatic test_basic();
        if2.out_rdy = 1'b1;
        if2.arg_stb = 1'b1; if2.arg_dat = 8'h11;
        #1;
        total++; if (if2.arg_rdy !== 1'b1) begin bad++; $display("FAIL basic_rdy got=%b exp=1", if2.arg_rdy); end
        tick();
        total++; if (if2.out_stb !== 1'b0) begin bad++; $display("FAIL basic_early_stb got=%b exp=0", if2.out_stb); end
        if2.arg_dat = 8'h22;
        tick();
        if2.arg_stb = 1'b0;
        total++; if (if2.out_stb !== 1'b1) begin bad++; $display("FAIL basic_stb got=%b exp=1", if2.out_stb); end
        total++; if (if2.out_dat !== 16'h2211) begin bad++; $display("FAIL basic_dat got=%h exp=2211", if2.out_dat); end
        tick();
        total++; if (if2.out_stb !== 1'b0) begin bad++; $display("FAIL basic_drop got=%b exp=0", if2.out_stb); end
    endtask

    task automatic test_backpressure();
        if2.out_rdy = 1'b0;
        if2.arg_stb = 1'b1; if2.arg_dat = 8'hA1;
        tick();
        if2.arg_dat = 8'hA2;
        tick();
        total++; if (if2.out_stb !== 1'b1) begin bad++; $display("FAIL bp_stb got=%b exp=1", if2.out_stb); end
        total++; if (if2.out_dat !== 16'hA2A1) begin bad++; $display("FAIL bp_dat got=%h exp=a2a1", if2.out_dat); end
        if2.arg_dat = 8'hB1;
        #1;
        total++; if (if2.arg_rdy !== 1'b1) begin bad++; $display("FAIL bp_lane0_rdy got=%b exp=1", if2.arg_rdy); end
        tick();
        if2.arg_dat = 8'hB2;
        #1;
        total++; if (if2.arg_rdy !== 1'b0) begin bad++; $display("FAIL bp_final_rdy got=%b exp=0", if2.arg_rdy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (if2.out_dat !== 16'hA2A1) begin bad++; $display("FAIL bp_hold_dat got=%h exp=a2a1", if2.out_dat); end
            total++; if (if2.out_stb !== 1'b1) begin bad++; $display("FAIL bp_hold_stb got=%b exp=1", if2.out_stb); end
            total++; if (if2.arg_rdy !== 1'b0) begin bad++; $display("FAIL bp_hold_rdy got=%b exp=0", if2.arg_rdy); end
        end
        if2.out_rdy = 1'b1;
        #1;
        total++; if (if2.arg_rdy !== 1'b1) begin bad++; $display("FAIL bp_release_rdy got=%b exp=1", if2.arg_rdy); end
        tick();
        if2.arg_stb = 1'b0;
        total++; if (if2.out_stb !== 1'b1) begin bad++; $display("FAIL bp_cont_stb got=%b exp=1", if2.out_stb); end
        total++; if (if2.out_dat !== 16'hB2B1) begin bad++; $display("FAIL bp_next_dat got=%h exp=b2b1", if2.out_dat); end
        tick();
        total++; if (if2.out_stb !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", if2.out_stb); end
    endtask

    task automatic test_stream3();
        logic [23:0] w;
        if3.out_rdy = 1'b1;
        if3.arg_stb = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if3.arg_dat = 8'(i);
            #1;
            total++; if (if3.arg_rdy !== 1'b1) begin bad++; $display("FAIL s3_rdy[%0d] got=%b exp=1", i, if3.arg_rdy); end
            tick();
            total++;
            if (if3.out_stb !== ((i % 3) == 0)) begin
                bad++; $display("FAIL s3_stb[%0d] got=%b exp=%b", i, if3.out_stb, (i % 3) == 0);
            end
            if ((i % 3) == 0) begin
                w = {8'(i), 8'(i - 1), 8'(i - 2)};
                total++; if (if3.out_dat !== w) begin bad++; $display("FAIL s3_dat[%0d] got=%h exp=%h", i, if3.out_dat, w); end
            end
        end
        if3.arg_stb = 1'b0;
        tick();
        total++; if (if3.out_stb !== 1'b0) begin bad++; $display("FAIL s3_end got=%b exp=0", if3.out_stb); end
    endtask

    task automatic test_reset_mid();
        if2.out_rdy = 1'b1;
        if2.arg_stb = 1'b1; if2.arg_dat = 8'h55;
        tick();
        if2.arg_stb = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (if2.out_stb !== 1'b0) begin bad++; $display("FAIL rm_stb_in_reset got=%b exp=0", if2.out_stb); end
        total++; if (if2.arg_rdy !== 1'b1) begin bad++; $display("FAIL rm_rdy_in_reset got=%b exp=1", if2.arg_rdy); end
        tick();
        total++; if (if2.out_stb !== 1'b0) begin bad++; $display("FAIL rm_stb_reset2 got=%b exp=0", if2.out_stb); end
        rst = 1'b1;
        if2.arg_stb = 1'b1; if2.arg_dat = 8'h66;
        tick();
        total++; if (if2.out_stb !== 1'b0) begin bad++; $display("FAIL rm_partial_stb got=%b exp=0", if2.out_stb); end
        if2.arg_dat = 8'h77;
        tick();
        if2.arg_stb = 1'b0;
        total++; if (if2.out_stb !== 1'b1) begin bad++; $display("FAIL rm_stb got=%b exp=1", if2.out_stb); end
        total++; if (if2.out_dat !== 16'h7766) begin bad++; $display("FAIL rm_dat got=%h exp=7766", if2.out_dat); end
        tick();
    endtask

    task automatic test_reset_pending();
        if2.out_rdy = 1'b0;
        if2.arg_stb = 1'b1; if2.arg_dat = 8'h33;
        tick();
        if2.arg_dat = 8'h44;
        tick();
        if2.arg_stb = 1'b0;
        total++; if (if2.out_stb !== 1'b1) begin bad++; $display("FAIL rp_stb got=%b exp=1", if2.out_stb); end
        rst = 1'b0;
        #1;
        total++; if (if2.out_stb !== 1'b0) begin bad++; $display("FAIL rp_drop_stb got=%b exp=0", if2.out_stb); end
        total++; if (if2.out_dat !== 16'h0) begin bad++; $display("FAIL rp_drop_dat got=%h exp=0000", if2.out_dat); end
        tick();
        rst = 1'b1;
        if2.out_rdy = 1'b1;
        tick();
        total++; if (if2.out_stb !== 1'b0) begin bad++; $display("FAIL rp_after got=%b exp=0", if2.out_stb); end
    endtask

    // Reference: accepted arguments form words lane 0 first; completed words
    // queue until taken; the final lane of a word is refused only while an
    // older word is still waiting and the consumer is not taking it.
    task automatic test_random();
        logic [23:0] pend[$];
        logic [23:0] cur;
        int          cnt;
        int          sent;
        int          taken;
        int          cycles;
        logic        exp_rdy;
        logic        a_ack;
        logic        o_ack;
        cur = '0; cnt = 0; sent = 0; taken = 0; cycles = 0;
        while (taken < 1000 && cycles < 40000) begin
            if3.arg_stb = (sent < 3000) && ($urandom_range(0, 3) != 0);
            if3.arg_dat = 8'($urandom);
            if3.out_rdy = ($urandom_range(0, 1) == 1);
            #1;
            exp_rdy = !((cnt == 2) && (pend.size() > 0) && !if3.out_rdy);
            total++; if (if3.arg_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", cycles, if3.arg_rdy, exp_rdy); end
            total++; if (if3.out_stb !== (pend.size() > 0)) begin bad++; $display("FAIL rnd_stb cyc=%0d got=%b exp=%b", cycles, if3.out_stb, pend.size() > 0); end
            if (pend.size() > 0) begin
                total++; if (if3.out_dat !== pend[0]) begin bad++; $display("FAIL rnd_dat cyc=%0d got=%h exp=%h", cycles, if3.out_dat, pend[0]); end
            end
            a_ack = if3.arg_stb && exp_rdy;
            o_ack = (pend.size() > 0) && if3.out_rdy;
            tick();
            cycles++;
            if (o_ack) begin
                void'(pend.pop_front());
                taken++;
            end
            if (a_ack) begin
                cur[cnt*8 +: 8] = if3.arg_dat;
                cnt++;
                sent++;
                if (cnt == 3) begin
                    pend.push_back(cur);
                    cur = '0;
                    cnt = 0;
                end
            end
        end
        if3.arg_stb = 1'b0;
        total++; if (taken !== 1000) begin bad++; $display("FAIL rnd_words got=%0d exp=1000", taken); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stream3();
        test_reset_mid();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
